// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   NOP              - instruction word used for IF/ID bubbles
//   PC_STEP          - sequential PC increment
//   DEFAULT_RESET_PC - default reset vector
//   ifid_t           - IF/ID pipeline register contents
//   word_align()     - clears the byte-offset bits of an address
package ifu_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP, pc: 32'h0000_0000, pc4: 32'h0000_0000};

  // Masking keeps every address bit referenced while forcing bits [1:0] to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_chk.sv
// ifu_chk: simulation-only contract checker for ifu.
//   i_clk, i_rst          - clock and synchronous reset of the checked unit
//   i_stall, i_redirect   - control inputs of the checked unit
// With delay slots enabled, a redirect during a stall has no defined meaning
// (the delay-slot instruction would be both kept and held), so the upstream
// stages must never assert both together.
module ifu_chk #(
  parameter logic DELAY_SLOT = 1'b0
) (
  input logic i_clk,
  input logic i_rst,
  input logic i_stall,
  input logic i_redirect
);

  a_no_redirect_with_stall: assert property (
    @(posedge i_clk) disable iff (i_rst) !(DELAY_SLOT && i_redirect && i_stall)
  ) else $error("ifu_chk: redirect and stall asserted together with DELAY_SLOT=1");

endmodule

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter register with next-PC selection.
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_stall          - hold PC
//   i_redirect       - load i_redirect_pc (word-aligned)
//   i_redirect_pc    - branch/jump target
//   o_pc             - current PC (register output)
// Priority: reset > redirect > stall > PC+4 (wraps modulo 2^32).
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // Next-PC mux; redirect wins over stall so a branch taken during a stall is not lost.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = word_align(i_redirect_pc);
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end else begin
      w_pc_next = r_pc + PC_STEP;
    end
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= word_align(RESET_PC);
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit with IF/ID pipeline register.
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_stall                   - hold PC and IF/ID
//   i_flush                   - replace IF/ID with a bubble
//   i_redirect, i_redirect_pc - branch/jump redirect and target
//   o_im_addr                 - instruction memory address (= PC register)
//   i_im_data                 - instruction word for o_im_addr, same cycle
//   o_id_valid/instr/pc/pc4   - IF/ID register contents
//   o_fetch_cnt               - count of valid instructions loaded into IF/ID
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic        DELAY_SLOT = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_im_addr,
  input  logic [31:0] i_im_data,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc4,
  output logic [31:0] o_fetch_cnt
);

  logic [31:0] w_pc;
  ifid_t       r_ifid;
  ifid_t       w_ifid_next;
  logic [31:0] r_fetch_cnt;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_pc          (w_pc)
  );

  ifu_chk #(
    .DELAY_SLOT (DELAY_SLOT)
  ) u_chk (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_stall    (i_stall),
    .i_redirect (i_redirect)
  );

  // IF/ID next state. Without delay slots the word fetched in the redirect
  // cycle is on the wrong path and is squashed; a redirect also overrides a
  // stall here because the held instruction is equally wrong-path.
  always_comb begin
    w_ifid_next = r_ifid;
    if (i_flush) begin
      w_ifid_next = IFID_BUBBLE;
    end else if (i_redirect && !DELAY_SLOT) begin
      w_ifid_next = IFID_BUBBLE;
    end else if (i_stall) begin
      w_ifid_next = r_ifid;
    end else begin
      w_ifid_next = '{valid: 1'b1, instr: i_im_data, pc: w_pc, pc4: w_pc + PC_STEP};
    end
  end

  // IF/ID register and fetch counter; the counter steps only on fresh valid loads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ifid      <= IFID_BUBBLE;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_ifid <= w_ifid_next;
      if (!i_flush && !(i_redirect && !DELAY_SLOT) && !i_stall) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
        r_fetch_cnt <= r_fetch_cnt;
      end
    end
  end

  assign o_im_addr   = w_pc;
  assign o_id_valid  = r_ifid.valid;
  assign o_id_instr  = r_ifid.instr;
  assign o_id_pc     = r_ifid.pc;
  assign o_id_pc4    = r_ifid.pc4;
  assign o_fetch_cnt = r_fetch_cnt;

endmodule
